// File: rtl/dc_step_scheduler_if.sv
// Bundle of the control and DC-level-table signals of dc_step_scheduler.
//   master : sequence control inputs (Start, Abort, Mode, ExtStep, StartAddr,
//            EndAddr, LoopCount, DwellCycles, HoldoffCycles); observes outputs
//   slave  : the scheduler; drives Addr, StepOut, Busy, Done, PassIdx
interface dc_step_scheduler_if #(
    parameter int ADDR_W  = 7,
    parameter int DWELL_W = 32
);
    logic               Start;
    logic               Abort;
    logic               Mode;
    logic               ExtStep;
    logic [ADDR_W-1:0]  StartAddr;
    logic [ADDR_W-1:0]  EndAddr;
    logic [15:0]        LoopCount;
    logic [DWELL_W-1:0] DwellCycles;
    logic [15:0]        HoldoffCycles;
    logic [ADDR_W-1:0]  Addr;
    logic               StepOut;
    logic               Busy;
    logic               Done;
    logic [15:0]        PassIdx;

    modport master (
        output Start, Abort, Mode, ExtStep, StartAddr, EndAddr,
               LoopCount, DwellCycles, HoldoffCycles,
        input  Addr, StepOut, Busy, Done, PassIdx
    );

    modport slave (
        input  Start, Abort, Mode, ExtStep, StartAddr, EndAddr,
               LoopCount, DwellCycles, HoldoffCycles,
        output Addr, StepOut, Busy, Done, PassIdx
    );
endinterface

// File: rtl/dc_step_scheduler.sv
// dc_step_scheduler: steps a DC-level LUT address from StartAddr to EndAddr
// (modulo 2^ADDR_W), repeating for LoopCount passes (0 = until Abort). Levels
// advance on ExtStep pulses (Mode=0) or every max(DwellCycles,1) cycles (Mode=1).
// Ports:
//   Clk    : clock, rising edge
//   Reset  : asynchronous active-low reset
//   bus    : dc_step_scheduler_if.slave (control inputs, Addr/StepOut/Busy/
//            Done/PassIdx outputs)
// Build option: define DC_SCHED_HOLDOFF_EN to ignore ExtStep for HoldoffCycles
// cycles after each accepted ExtStep.
module dc_step_scheduler #(
    parameter int ADDR_W  = 7,
    parameter int DWELL_W = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    dc_step_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  start_q, end_q;
    logic [15:0]        loop_q;
    logic [15:0]        pass_q, pass_d;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] timer_q, timer_d;
    logic               mode_q;
    logic               step_q, step_d;
    logic               ext_ok;
    logic               advance;

    // Dwell of 0 behaves like 1: the timer counts down to 0 and fires there.
    function automatic logic [DWELL_W-1:0] timer_reload(input logic [DWELL_W-1:0] d);
        return (d <= DWELL_W'(1)) ? '0 : d - DWELL_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef DC_SCHED_HOLDOFF_EN
    logic [15:0] hold_cfg_q;
    logic [15:0] hold_q, hold_d;
    assign ext_ok = bus.ExtStep && (hold_q == 16'd0);
`else
    logic unused_holdoff;
    assign unused_holdoff = ^bus.HoldoffCycles;
    assign ext_ok = bus.ExtStep;
`endif

    assign advance = mode_q ? (timer_q == '0) : ext_ok;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        timer_d = timer_q;
        step_d  = 1'b0;
`ifdef DC_SCHED_HOLDOFF_EN
        hold_d  = (hold_q != 16'd0) ? hold_q - 16'd1 : 16'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Start && !bus.Abort) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    addr_d  = bus.StartAddr;
                    pass_d  = 16'd0;
                    step_d  = 1'b1;
                    timer_d = timer_reload(bus.DwellCycles);
`ifdef DC_SCHED_HOLDOFF_EN
                    hold_d  = 16'd0;
`endif
                end
            end
            S_RUN: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (mode_q)
                        timer_d = (timer_q == '0) ? timer_reload(dwell_q) : timer_q - DWELL_W'(1);
`ifdef DC_SCHED_HOLDOFF_EN
                    if (!mode_q && ext_ok) hold_d = hold_cfg_q;
`endif
                    if (advance) begin
                        if (addr_q != end_q) begin
                            addr_d = addr_q + 1'b1;
                            step_d = 1'b1;
                        end else begin
                            // End of a pass: either finish (address holds) or restart.
                            pass_d = sat_inc16(pass_q);
                            if (loop_q != 16'd0 && pass_d == loop_q) begin
                                state_d = S_DONE;
                            end else begin
                                addr_d = start_q;
                                step_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pass_q  <= 16'd0;
            timer_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            timer_q <= timer_d;
            step_q  <= step_d;
        end
    end

    // Sequence configuration is captured once, as LOAD hands over to RUN.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            start_q <= '0;
            end_q   <= '0;
            loop_q  <= 16'd0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else if (state_q == S_LOAD) begin
            start_q <= bus.StartAddr;
            end_q   <= bus.EndAddr;
            loop_q  <= bus.LoopCount;
            dwell_q <= bus.DwellCycles;
            mode_q  <= bus.Mode;
        end
    end

`ifdef DC_SCHED_HOLDOFF_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hold_cfg_q <= 16'd0;
            hold_q     <= 16'd0;
        end else begin
            if (state_q == S_LOAD) hold_cfg_q <= bus.HoldoffCycles;
            hold_q <= hold_d;
        end
    end
`endif

    assign bus.Addr    = addr_q;
    assign bus.StepOut = step_q;
    assign bus.Busy    = (state_q == S_LOAD) || (state_q == S_RUN);
    assign bus.Done    = (state_q == S_DONE);
    assign bus.PassIdx = pass_q;

endmodule
